serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
// - Bit-serial WIDTH-bit adder: one full-adder slice (two half_adder stages plus OR) per clock, LSB first.
// - Consumes the sum/carry pair produced by the half-adder datapath and registers the carry between bits.
// - Trades latency for area in the Hack ALU add path.
// - Valid/ready handshake on input and output.
//
// PARAMETERS
// - WIDTH  16  operand/result width in bits; legal range >= 2.
// - CNT_W  5   bit counter width; must satisfy 2**CNT_W > WIDTH.
//
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operands a/b are valid
// - in_ready   out  1      block can accept operands; high only in IDLE
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - sub        in   1      subtract select (port present only when SERIAL_ADDER_SUB_EN is defined)
// - out_valid  out  1      sum/carry valid; high only in DONE
// - out_ready  in   1      consumer accepts the result
// - sum        out  WIDTH  result bits
// - carry      out  1      carry out of bit WIDTH-1
// - busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, shift regs/sum=0, carry=0, count=0, out_valid=0, busy=0.
//   - in_ready is combinational from state, so it reads 1 while in reset.
//   - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
// - FSM states:
//   - IDLE: in_ready=1. On in_valid at edge T: latch a->A_sh, b->B_sh, clear carry and count -> RUN.
//   - RUN, per edge:
//     - s = A_sh[0]^B_sh[0]^c.
//     - c' = A_sh[0]&B_sh[0] | c&(A_sh[0]^B_sh[0]).
//     - A_sh, B_sh shift right by 1.
//     - Result reg shifts right with s entering the MSB.
//     - count increments.
//     - When count==WIDTH-1 at the edge -> DONE.
//   - DONE: out_valid=1; sum and carry hold stable. On out_ready -> IDLE, out_valid drops the next cycle.
// - Latency: operands accepted at edge T; out_valid first high after edge T+WIDTH.
// - Throughput: one result per WIDTH+2 cycles minimum.
// - in_valid is ignored while not IDLE; a/b may change freely after acceptance.
// - Backpressure: out_ready low holds DONE indefinitely, with sum/carry unchanged.
// - Arithmetic: {carry,sum} = a + b mod 2**(WIDTH+1), unsigned; wrap-around is reported via carry only.
// - sum/carry outputs are registered and change only on the RUN->DONE transition.
//   - Their value outside DONE is don't-care for checking.
//
// CONFIGURATION
// - SERIAL_ADDER_SUB_EN defined:
//   - sub port exists and is latched with a on acceptance.
//   - sub=1: B_sh loads ~b and the carry init is 1, so sum = a - b mod 2**WIDTH.
//   - In subtract mode carry=1 means no borrow (a >= b).
//   - sub=0: behaviour identical to the undefined case.
// - SERIAL_ADDER_SUB_EN undefined: no sub port; carry init is always 0; add only.
//
// TESTING
// - WIDTH=16, a=0x0003, b=0x0005 -> out_valid rises 16 cycles after acceptance; sum=0x0008, carry=0.
// - a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1 (full-width carry ripple).
// - Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/carry stable, in_ready=0.
//   - Pulse in_valid with a new a/b during this window -> ignored.
//   - Then out_ready=1 -> IDLE; the next op starts normally.
// - Reset mid-operation: assert rst_n=0 at cycle 7 of RUN -> immediately state=IDLE, out_valid=0, busy=0.
//   - Next op 0x1234+0x1111 -> sum=0x2345.
// - SERIAL_ADDER_SUB_EN: a=5, b=3, sub=1 -> sum=0x0002, carry=1.
//   - a=3, b=5, sub=1 -> sum=0xFFFE, carry=0.
// - Back-to-back: in_valid held high with out_ready=1 -> second op accepted exactly 2 cycles after first out_valid rises.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice per clock, LSB first, registered carry between bits.
// Latency: operands accepted at edge T, out_valid first high after edge T+WIDTH; one result per WIDTH+2 cycles.
// Backpressure: out_ready low holds DONE with sum/carry frozen; in_ready is high only in IDLE.
// SERIAL_ADDER_SUB_EN adds the sub port for a - b (b inverted, carry-in 1).
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             c;
    logic [CNT_W-1:0] count;
    logic             last;

    logic [WIDTH-1:0] b_ld;
    logic             c_init;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: add ~b with a carry-in of one.
    assign b_ld   = sub ? ~b : b;
    assign c_init = sub;
`else
    assign b_ld   = b;
    assign c_init = 1'b0;
`endif

    // Full adder built from two half-adder stages plus an OR.
    logic hs1, hc1, s, hc2, c_nx;
    assign hs1  = a_sh[0] ^ b_sh[0];
    assign hc1  = a_sh[0] & b_sh[0];
    assign s    = hs1 ^ c;
    assign hc2  = hs1 & c;
    assign c_nx = hc1 | hc2;

    assign res_nx = {s, res_sh[WIDTH-1:1]};
    assign last   = (count == CNT_W'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            c      <= 1'b0;
            count  <= '0;
            sum    <= '0;
            carry  <= 1'b0;
        end else if ((state == IDLE) && in_valid) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            c     <= c_init;
            count <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            c      <= c_nx;
            count  <= count + 1'b1;
            // Outputs only move on the final bit so they stay frozen through DONE.
            if (last) begin
                sum   <= res_nx;
                carry <= c_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=16), with subtract vectors when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    // Accept one operand pair, check latency and result, then acknowledge.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic [WIDTH-1:0] es, input logic ec);
        int n = 0;
        wait_idle(tag);
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd16);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_carry"}, 32'(carry), 32'(ec));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ack"}, 32'(out_valid), 32'd0);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic run_sub(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic [WIDTH-1:0] es, input logic ec);
        sub = 1'b1;
        run_op(tag, ta, tb_, es, ec);
        sub = 1'b0;
    endtask
`endif

    initial begin
        int n;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("add3_5", 16'h0003, 16'h0005, 16'h0008, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("allones", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        run_op("alt", 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);
        run_op("zero", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_op("msb", 16'h8001, 16'h8001, 16'h0002, 1'b1);

        // Backpressure: hold DONE for 10 cycles and poke in_valid meanwhile.
        wait_idle("bp");
        a = 16'h1234;
        b = 16'h4321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_lat", 32'(n), 32'd16);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 16'h1111;
                b = 16'h2222;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_sum", 32'(sum), 32'h5555);
            chk("bp_carry", 32'(carry), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ov", 32'(out_valid), 32'd0);
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        chk("bp_release_busy", 32'(busy), 32'd0);
        run_op("after_bp", 16'h0003, 16'h0005, 16'h0008, 1'b0);

        // Reset in the middle of RUN.
        wait_idle("mid");
        a = 16'hFFFF;
        b = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 16'h1234, 16'h1111, 16'h2345, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        wait_idle("b2b");
        a = 16'h0010;
        b = 16'h0020;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        a = 16'h0100;
        b = 16'h0200;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 32'(n), 32'd16);
        chk("b2b_sum1", 32'(sum), 32'h0030);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(busy && !out_valid) && n < 10);
        chk("b2b_gap", 32'(n), 32'd2);
        in_valid = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_lat2", 32'(n), 32'd16);
        chk("b2b_sum2", 32'(sum), 32'h0300);
        chk("b2b_carry2", 32'(carry), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        run_sub("sub5_3", 16'h0005, 16'h0003, 16'h0002, 1'b1);
        run_sub("sub3_5", 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
        run_sub("sub_eq", 16'h1234, 16'h1234, 16'h0000, 1'b1);
        run_op("sub0_add", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
